vga_ctrl: RTL and testbench

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_ctrl.sv | 115 +++++++++++
 tb/tb_vga_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ctrl.sv
// VGA timing generator: free-running h/v counters, look-ahead pixel request
// and a single registered output stage for sync, data enable and colour.
module vga_ctrl #(
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 40,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int PIX_LEAD = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [23:0] pix_data,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_END   = 11'(H_SYNC);
    localparam logic [10:0] H_VIS_LO = 11'(H_START);
    localparam logic [10:0] H_VIS_HI = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] H_REQ_LO = 11'(H_START - PIX_LEAD);
    localparam logic [10:0] H_REQ_HI = 11'(H_START + H_ACTIVE - PIX_LEAD);

    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_END   = 10'(V_SYNC);
    localparam logic [9:0]  V_VIS_LO = 10'(V_START);
    localparam logic [9:0]  V_VIS_HI = 10'(V_START + V_ACTIVE);
    localparam logic [9:0]  X_OFS    = 10'(H_START - PIX_LEAD);
    localparam logic [9:0]  Y_OFS    = 10'(V_START);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        h_vis;
    logic        v_vis;
    logic        h_req;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Disabling parks the counters at the origin so re-enable starts a fresh frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign h_vis = (h_cnt >= H_VIS_LO) && (h_cnt < H_VIS_HI);
    assign v_vis = (v_cnt >= V_VIS_LO) && (v_cnt < V_VIS_HI);
    assign h_req = (h_cnt >= H_REQ_LO) && (h_cnt < H_REQ_HI);

    // Requests run PIX_LEAD clocks ahead of the visible window so the source
    // data lands exactly on the cycle the output register samples it.
    // The subtraction wraps modulo 1024, which is exact because the
    // result is always below H_ACTIVE.
    always_comb begin
        pix_req = en && v_vis && h_req;
        pix_x   = '0;
        pix_y   = '0;
        if (pix_req) begin
            pix_x = h_cnt[9:0] - X_OFS;
            pix_y = v_cnt - Y_OFS;
        end
    end

    // All panel-facing signals come from one register stage so they stay aligned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !(h_cnt < HS_END);
            vsync       <= !(v_cnt < VS_END);
            de          <= h_vis && v_vis;
            rgb         <= (h_vis && v_vis) ? pix_data : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl: default timing with PIX_LEAD 1 and 3, plus a
// reduced-geometry instance for wrap points and full-frame periods.
module tb_vga_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, en, rstn_r, en_r;
    logic [23:0] pd1, pd3, pdr;
    logic        req1, req3, reqr;
    logic [9:0]  x1, y1, x3, y3, xr, yr;
    logic        hs1, vs1, de1, fs1, hs3, vs3, de3, fs3, hsr, vsr, der, fsr;
    logic [23:0] rgb1, rgb3, rgbr;

    int tests = 0;
    int fails = 0;
    int n = 0;

    vga_ctrl #(.PIX_LEAD(1)) u1 (
        .clk(clk), .rstn(rstn), .en(en), .pix_data(pd1), .pix_req(req1),
        .pix_x(x1), .pix_y(y1), .hsync(hs1), .vsync(vs1), .de(de1),
        .rgb(rgb1), .frame_start(fs1));

    vga_ctrl #(.PIX_LEAD(3)) u3 (
        .clk(clk), .rstn(rstn), .en(en), .pix_data(pd3), .pix_req(req3),
        .pix_x(x3), .pix_y(y3), .hsync(hs3), .vsync(vs3), .de(de3),
        .rgb(rgb3), .frame_start(fs3));

    vga_ctrl #(.H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
               .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1),
               .PIX_LEAD(1)) ur (
        .clk(clk), .rstn(rstn_r), .en(en_r), .pix_data(pdr), .pix_req(reqr),
        .pix_x(xr), .pix_y(yr), .hsync(hsr), .vsync(vsr), .de(der),
        .rgb(rgbr), .frame_start(fsr));

    // Pixel sources: coordinate {y,x} delayed by the source latency.
    logic [19:0] q1 = '0, q3a = '0, q3b = '0, q3c = '0, qr = '0;
    always @(posedge clk) begin
        q1  <= {y1, x1};
        q3a <= {y3, x3};
        q3b <= q3a;
        q3c <= q3b;
        qr  <= {yr, xr};
    end
    assign pd1 = {q1[17:10], q1[7:0], 8'hA5};
    assign pd3 = {q3c[17:10], q3c[7:0], 8'hA5};
    assign pdr = {qr[17:10], qr[7:0], 8'hA5};

    // Expected {hsync, vsync, de, rgb, frame_start} after sampling counter (ph,pv).
    function automatic logic [27:0] exp_out(int ph, int pv, int hs, int hst, int ha,
                                            int vs, int vst, int va);
        logic        v;
        logic [23:0] c;
        v = (ph >= hst) && (ph < hst + ha) && (pv >= vst) && (pv < vst + va);
        c = v ? {8'(pv - vst), 8'(ph - hst), 8'hA5} : 24'h0;
        return {!(ph < hs), !(pv < vs), v, c, (ph == 0 && pv == 0)};
    endfunction

    // Expected {pix_req, pix_x, pix_y} for live counter (hc,vc).
    function automatic logic [20:0] exp_req(int hc, int vc, int hst, int ha,
                                            int vst, int va, int lead);
        logic r;
        r = (hc >= hst - lead) && (hc < hst + ha - lead) && (vc >= vst) && (vc < vst + va);
        return r ? {1'b1, 10'(hc + lead - hst), 10'(vc - vst)} : 21'h0;
    endfunction

    task automatic tick;
        @(negedge clk);
        n++;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        en   = 1'b1;
        #13;
        tests++;
        if ({hs1, vs1, de1, rgb1, fs1} !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_regs got %h exp %h", {hs1, vs1, de1, rgb1, fs1},
                     {1'b1, 1'b1, 1'b0, 24'h0, 1'b0});
        end
        tests++;
        if ({req1, x1, y1} !== 21'h0) begin
            fails++;
            $display("FAIL reset_req got %h exp 0", {req1, x1, y1});
        end
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
    endtask

    // First three lines: sync pulse widths and the single frame_start.
    task automatic test_sync;
        int hs_low, vs_low, fs_cnt;
        logic [27:0] e;
        hs_low = 0; vs_low = 0; fs_cnt = 0;
        while (n < 3 * 1056) begin
            tick;
            e = exp_out((n - 1) % 1056, (n - 1) / 1056, 128, 216, 800, 2, 35, 480);
            tests++;
            if ({hs1, vs1, de1, rgb1, fs1} !== e) begin
                fails++;
                if (fails < 20) $display("FAIL sync_regs n=%0d got %h exp %h", n,
                                         {hs1, vs1, de1, rgb1, fs1}, e);
            end
            if (n == 1) begin
                tests++;
                if (fs1 !== 1'b1 || hs1 !== 1'b0) begin
                    fails++;
                    $display("FAIL first_edge fs=%b hs=%b exp fs=1 hs=0", fs1, hs1);
                end
            end
            hs_low += (hs1 == 1'b0);
            vs_low += (vs1 == 1'b0);
            fs_cnt += (fs1 == 1'b1);
        end
        tests++;
        if (hs_low != 384) begin
            fails++;
            $display("FAIL hsync_low got %0d exp 384", hs_low);
        end
        tests++;
        if (vs_low != 2112) begin
            fails++;
            $display("FAIL vsync_low got %0d exp 2112", vs_low);
        end
        tests++;
        if (fs_cnt != 1) begin
            fails++;
            $display("FAIL frame_start_cnt got %0d exp 1", fs_cnt);
        end
    endtask

    // Through lines 35/36: request window, de run and rgb for both latencies.
    task automatic test_pixels;
        int hc, vc, ph, pv;
        int f1_h, l1_h, f3_h, de_first, de_run, de_max;
        logic [9:0] f1_x, f1_y, l1_x;
        logic [27:0] e;
        logic [20:0] r1, r3;
        f1_h = -1; l1_h = -1; f3_h = -1; de_first = -1; de_run = 0; de_max = 0;
        f1_x = '1; f1_y = '1; l1_x = '1;
        while (n < 37 * 1056) begin
            tick;
            hc = n % 1056; vc = n / 1056;
            ph = (n - 1) % 1056; pv = (n - 1) / 1056;
            e  = exp_out(ph, pv, 128, 216, 800, 2, 35, 480);
            r1 = exp_req(hc, vc, 216, 800, 35, 480, 1);
            r3 = exp_req(hc, vc, 216, 800, 35, 480, 3);
            tests++;
            if ({hs1, vs1, de1, rgb1, fs1} !== e || {hs3, vs3, de3, rgb3, fs3} !== e) begin
                fails++;
                if (fails < 20) $display("FAIL pix_regs n=%0d got %h/%h exp %h", n,
                                         {hs1, vs1, de1, rgb1, fs1}, {hs3, vs3, de3, rgb3, fs3}, e);
            end
            tests++;
            if ({req1, x1, y1} !== r1 || {req3, x3, y3} !== r3) begin
                fails++;
                if (fails < 20) $display("FAIL pix_req n=%0d got %h/%h exp %h/%h", n,
                                         {req1, x1, y1}, {req3, x3, y3}, r1, r3);
            end
            if (vc == 35 && req1 === 1'b1) begin
                if (f1_h < 0) begin f1_h = hc; f1_x = x1; f1_y = y1; end
                l1_h = hc; l1_x = x1;
            end
            if (vc == 35 && req3 === 1'b1 && f3_h < 0) f3_h = hc;
            if (pv == 35) begin
                if (de1 === 1'b1) begin
                    if (de_first < 0) de_first = hc;
                    de_run++;
                    if (de_run > de_max) de_max = de_run;
                end else de_run = 0;
            end
        end
        tests++;
        if (f1_h != 215 || f1_x !== 10'd0 || f1_y !== 10'd0) begin
            fails++;
            $display("FAIL first_req h=%0d x=%0d y=%0d exp 215/0/0", f1_h, f1_x, f1_y);
        end
        tests++;
        if (l1_h != 1014 || l1_x !== 10'd799) begin
            fails++;
            $display("FAIL last_req h=%0d x=%0d exp 1014/799", l1_h, l1_x);
        end
        tests++;
        if (f3_h != 213) begin
            fails++;
            $display("FAIL first_req_lead3 h=%0d exp 213", f3_h);
        end
        tests++;
        if (de_first != 217 || de_max != 800) begin
            fails++;
            $display("FAIL de_window first=%0d run=%0d exp 217/800", de_first, de_max);
        end
    endtask

    // Drop en at counter (500,37), hold 10 clocks, restore and check restart.
    task automatic test_enable;
        int fs_cnt;
        logic [27:0] e;
        while (n < 37 * 1056 + 500) tick;
        en = 1'b0;
        #1;
        tests++;
        if (req1 !== 1'b0 || req3 !== 1'b0) begin
            fails++;
            $display("FAIL en_req_comb got %b/%b exp 0", req1, req3);
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            tests++;
            if ({hs1, vs1, de1, rgb1, fs1, req1, x1, y1} !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 21'h0}) begin
                fails++;
                if (fails < 20) $display("FAIL en_idle i=%0d got %h exp %h", i,
                                         {hs1, vs1, de1, rgb1, fs1, req1, x1, y1},
                                         {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 21'h0});
            end
        end
        en = 1'b1;
        n = 0;
        fs_cnt = 0;
        while (n < 2 * 1056 + 10) begin
            tick;
            e = exp_out((n - 1) % 1056, (n - 1) / 1056, 128, 216, 800, 2, 35, 480);
            tests++;
            if ({hs1, vs1, de1, rgb1, fs1} !== e) begin
                fails++;
                if (fails < 20) $display("FAIL restart n=%0d got %h exp %h", n,
                                         {hs1, vs1, de1, rgb1, fs1}, e);
            end
            fs_cnt += (fs1 == 1'b1);
        end
        tests++;
        if (fs_cnt != 1) begin
            fails++;
            $display("FAIL restart_fs_cnt got %0d exp 1", fs_cnt);
        end
    endtask

    task automatic test_async_reset;
        #2;
        rstn = 1'b0;
        #2;
        tests++;
        if ({hs1, vs1, de1, rgb1, fs1, req1, x1, y1} !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 21'h0}) begin
            fails++;
            $display("FAIL async_reset got %h exp idle", {hs1, vs1, de1, rgb1, fs1, req1, x1, y1});
        end
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        tick;
        tests++;
        if (hs1 !== 1'b0 || fs1 !== 1'b1) begin
            fails++;
            $display("FAIL after_reset hs=%b fs=%b exp 0/1", hs1, fs1);
        end
    endtask

    // Reduced geometry: 10x5 frame, every wrap checked cycle by cycle.
    task automatic test_reduced;
        int de_cnt, fs_cnt, fs_prev, fs_per;
        logic [27:0] e;
        logic [20:0] r;
        rstn_r = 1'b1;
        n = 0;
        de_cnt = 0; fs_cnt = 0;
        while (n < 176) begin
            tick;
            e = exp_out((n - 1) % 10, ((n - 1) / 10) % 5, 2, 4, 4, 1, 2, 2);
            r = exp_req(n % 10, (n / 10) % 5, 4, 4, 2, 2, 1);
            tests++;
            if ({hsr, vsr, der, rgbr, fsr, reqr, xr, yr} !== {e, r}) begin
                fails++;
                if (fails < 20) $display("FAIL reduced n=%0d got %h exp %h", n,
                                         {hsr, vsr, der, rgbr, fsr, reqr, xr, yr}, {e, r});
            end
            if (n <= 150) begin
                de_cnt += (der == 1'b1);
                fs_cnt += (fsr == 1'b1);
            end
        end
        tests++;
        if (de_cnt != 24 || fs_cnt != 3) begin
            fails++;
            $display("FAIL reduced_counts de=%0d fs=%0d exp 24/3", de_cnt, fs_cnt);
        end
        // counter now at (6,2): de is high, reset lands mid-visible
        rstn_r = 1'b0;
        #1;
        tests++;
        if ({hsr, vsr, der, rgbr, fsr, reqr, xr, yr} !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 21'h0}) begin
            fails++;
            $display("FAIL reduced_async got %h exp idle", {hsr, vsr, der, rgbr, fsr, reqr, xr, yr});
        end
        @(negedge clk);
        rstn_r = 1'b1;
        n = 0;
        fs_prev = -1; fs_per = -1;
        while (n < 60) begin
            tick;
            if (n == 1) begin
                tests++;
                if (hsr !== 1'b0 || fsr !== 1'b1) begin
                    fails++;
                    $display("FAIL reduced_release hs=%b fs=%b exp 0/1", hsr, fsr);
                end
            end
            if (fsr === 1'b1) begin
                if (fs_prev >= 0 && fs_per < 0) fs_per = n - fs_prev;
                fs_prev = n;
            end
        end
        tests++;
        if (fs_per != 50) begin
            fails++;
            $display("FAIL reduced_frame_period got %0d exp 50", fs_per);
        end
    endtask

    initial begin
        rstn_r = 1'b0;
        en_r   = 1'b1;
        test_reset;
        test_sync;
        test_pixels;
        test_enable;
        test_async_reset;
        test_reduced;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
